// File: rtl/csi_rx_pkg.sv
// Shared constants and types for the CSI-2 receive packet handler.
// Latency: n/a (types, constants and one pure helper function).
// Backpressure: n/a.
package csi_rx_pkg;

  // Data types of the short sync packets and the default accepted pixel format.
  localparam logic [5:0] DT_FS       = 6'h00;
  localparam logic [5:0] DT_FE       = 6'h01;
  localparam logic [5:0] DT_LS       = 6'h02;
  localparam logic [5:0] DT_LE       = 6'h03;
  localparam logic [5:0] DT_RAW8     = 6'h2A;
  // Data types at or above this value are long packets.
  localparam logic [5:0] DT_LONG_MIN = 6'h10;

  typedef enum logic [1:0] {
    IDLE,
    PAYLOAD,
    WAIT_END
  } state_t;

  // Hamming ECC column for header data bit k (index 0 = bit 0). Each ECC bit i
  // is the parity of all data bits whose column has bit i set, so a single
  // flipped data bit k produces exactly ECC_COL[k] as its syndrome.
  localparam logic [23:0][5:0] ECC_COL = {
    6'h3B, 6'h37, 6'h2F, 6'h1F, 6'h38, 6'h34, 6'h32, 6'h31,
    6'h2C, 6'h2A, 6'h29, 6'h26, 6'h25, 6'h23, 6'h1C, 6'h1A,
    6'h19, 6'h16, 6'h15, 6'h13, 6'h0E, 6'h0D, 6'h0B, 6'h07
  };

  // Byte enables for a payload word given how many payload bytes are still due.
  function automatic logic [3:0] byte_mask(input logic [16:0] rem);
    logic [3:0] m;
    if (rem >= 17'd4) begin
      m = 4'b1111;
    end else begin
      case (rem[1:0])
        2'd1:    m = 4'b0001;
        2'd2:    m = 4'b0011;
        2'd3:    m = 4'b0111;
        default: m = 4'b0000;
      endcase
    end
    return m;
  endfunction

endpackage

// File: rtl/csi_rx_packet_handler_if.sv
// Bus between the lane merger, the packet handler and its downstream consumers.
// Latency: n/a (signal bundle only).
// Backpressure: none; the word stream cannot be stalled and consumers must keep up.
// Ports: data_in/data_valid from the lane merger; payload_* to the pixel unpacker;
//        pkt_*, sync pulses and status pulses to the timing generator.
interface csi_rx_packet_handler_if;
  logic [31:0] data_in;
  logic        data_valid;
  logic [31:0] payload_data;
  logic        payload_valid;
  logic [3:0]  payload_byte_en;
  logic        payload_last;
  logic        pkt_hdr_valid;
  logic [5:0]  pkt_dt;
  logic [1:0]  pkt_vc;
  logic [15:0] pkt_wc;
  logic        frame_start;
  logic        frame_end;
  logic        line_start;
  logic        line_end;
  logic        ecc_corrected;
  logic        ecc_error;
  logic        truncated;
  logic        in_packet;

  // master: the side that produces words and consumes the handler's results.
  modport master (
    output data_in, data_valid,
    input  payload_data, payload_valid, payload_byte_en, payload_last,
    input  pkt_hdr_valid, pkt_dt, pkt_vc, pkt_wc,
    input  frame_start, frame_end, line_start, line_end,
    input  ecc_corrected, ecc_error, truncated, in_packet
  );

  // slave: the packet handler itself.
  modport slave (
    input  data_in, data_valid,
    output payload_data, payload_valid, payload_byte_en, payload_last,
    output pkt_hdr_valid, pkt_dt, pkt_vc, pkt_wc,
    output frame_start, frame_end, line_start, line_end,
    output ecc_corrected, ecc_error, truncated, in_packet
  );
endinterface

// File: rtl/csi_rx_hdr_ecc.sv
// CSI-2 packet header ECC generator: 24 header data bits -> 6-bit Hamming ECC.
// Latency: combinational.
// Backpressure: none.
// Ports: i_data = {WC_MSB, WC_LSB, DI}; o_ecc[5:0] = ECC, o_ecc[7:6] always 0.
module csi_rx_hdr_ecc
  import csi_rx_pkg::*;
(
  input  logic [23:0] i_data,
  output logic [7:0]  o_ecc
);

  always_comb begin
    o_ecc = 8'h00;
    for (int k = 0; k < 24; k++) begin
      if (i_data[k]) begin
        o_ecc[5:0] = o_ecc[5:0] ^ ECC_COL[k];
      end
    end
  end

endmodule

// File: rtl/csi_rx_packet_handler.sv
// CSI-2 packet splitter: header ECC check/correct, sync pulses, payload words with CRC stripped.
// Latency: 1 cycle from input word to any output (header word N -> pkt_*/pulses in N+1).
// Backpressure: none; every valid word is consumed the cycle it arrives.
// Ports: clock, reset (sync, active-high); csi.slave carries data_in/data_valid in and
//        payload_*, pkt_*, frame/line pulses, ecc_corrected/ecc_error/truncated, in_packet out.
module csi_rx_packet_handler
  import csi_rx_pkg::*;
#(
  parameter bit         DT_FILTER_EN = 1'b0,
  parameter logic [5:0] DT_FILTER    = DT_RAW8
) (
  input  logic                    clock,
  input  logic                    reset,
  csi_rx_packet_handler_if.slave  csi
);

  state_t      r_state;
  logic [16:0] r_remaining;  // one bit wider than WC so 0xFFFF cannot wrap
  logic [31:0] r_payload_data;
  logic        r_payload_valid;
  logic [3:0]  r_payload_byte_en;
  logic        r_payload_last;
  logic        r_pkt_hdr_valid;
  logic [5:0]  r_pkt_dt;
  logic [1:0]  r_pkt_vc;
  logic [15:0] r_pkt_wc;
  logic        r_frame_start;
  logic        r_frame_end;
  logic        r_line_start;
  logic        r_line_end;
  logic        r_ecc_corrected;
  logic        r_ecc_error;
  logic        r_truncated;
  logic        r_in_packet;

  logic [7:0]  w_ecc;
  logic [5:0]  w_syn;
  logic [23:0] w_hdr;
  logic        w_col_hit;
  logic        w_hdr_bad;
  logic [5:0]  w_dt;
  logic [1:0]  w_vc;
  logic [15:0] w_wc;
  logic        w_filtered;
  logic        w_unused;

  csi_rx_hdr_ecc u_hdr_ecc (
    .i_data (csi.data_in[23:0]),
    .o_ecc  (w_ecc)
  );

  assign w_syn = csi.data_in[29:24] ^ w_ecc[5:0];

  // A syndrome equal to a data column pinpoints the flipped data bit.
  always_comb begin
    w_hdr     = csi.data_in[23:0];
    w_col_hit = 1'b0;
    for (int k = 0; k < 24; k++) begin
      if (w_syn == ECC_COL[k]) begin
        w_hdr[k]  = ~csi.data_in[k];
        w_col_hit = 1'b1;
      end
    end
  end

  // A one-hot syndrome means a flipped ECC bit: data is intact. Anything that is
  // neither zero, one-hot nor a data column is a multi-bit error.
  assign w_hdr_bad  = (w_syn != 6'd0) && !$onehot(w_syn) && !w_col_hit;
  assign w_dt       = w_hdr[5:0];
  assign w_vc       = w_hdr[7:6];
  assign w_wc       = w_hdr[23:8];
  assign w_filtered = DT_FILTER_EN && (w_dt != DT_FILTER);

  // Bits 31:30 of the header word and the upper ECC bits carry no information.
  assign w_unused = ^{csi.data_in[31:30], w_ecc[7:6]};

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state           <= IDLE;
      r_remaining       <= '0;
      r_payload_data    <= '0;
      r_payload_valid   <= 1'b0;
      r_payload_byte_en <= '0;
      r_payload_last    <= 1'b0;
      r_pkt_hdr_valid   <= 1'b0;
      r_pkt_dt          <= '0;
      r_pkt_vc          <= '0;
      r_pkt_wc          <= '0;
      r_frame_start     <= 1'b0;
      r_frame_end       <= 1'b0;
      r_line_start      <= 1'b0;
      r_line_end        <= 1'b0;
      r_ecc_corrected   <= 1'b0;
      r_ecc_error       <= 1'b0;
      r_truncated       <= 1'b0;
      r_in_packet       <= 1'b0;
    end else begin
      // Pulses default low so each lasts exactly one cycle.
      r_payload_valid <= 1'b0;
      r_payload_last  <= 1'b0;
      r_pkt_hdr_valid <= 1'b0;
      r_frame_start   <= 1'b0;
      r_frame_end     <= 1'b0;
      r_line_start    <= 1'b0;
      r_line_end      <= 1'b0;
      r_ecc_corrected <= 1'b0;
      r_ecc_error     <= 1'b0;
      r_truncated     <= 1'b0;

      case (r_state)
        IDLE: begin
          if (csi.data_valid) begin
            r_in_packet <= 1'b1;
            r_state     <= WAIT_END;
            if (w_hdr_bad) begin
              r_ecc_error <= 1'b1;
            end else begin
              r_pkt_hdr_valid <= 1'b1;
              r_pkt_dt        <= w_dt;
              r_pkt_vc        <= w_vc;
              r_pkt_wc        <= w_wc;
              r_ecc_corrected <= (w_syn != 6'd0);
              r_frame_start   <= (w_dt == DT_FS);
              r_frame_end     <= (w_dt == DT_FE);
              r_line_start    <= (w_dt == DT_LS);
              r_line_end      <= (w_dt == DT_LE);
              if ((w_dt >= DT_LONG_MIN) && (w_wc != 16'd0) && !w_filtered) begin
                r_remaining <= {1'b0, w_wc};
                r_state     <= PAYLOAD;
              end
            end
          end
        end

        PAYLOAD: begin
          if (csi.data_valid) begin
            r_payload_valid   <= 1'b1;
            r_payload_data    <= csi.data_in;
            r_payload_byte_en <= byte_mask(r_remaining);
            if (r_remaining <= 17'd4) begin
              // Last payload word; the CRC bytes that follow are dropped in WAIT_END.
              r_payload_last <= 1'b1;
              r_remaining    <= '0;
              r_state        <= WAIT_END;
            end else begin
              r_remaining <= r_remaining - 17'd4;
            end
          end else begin
            r_truncated <= 1'b1;
            r_remaining <= '0;
            r_in_packet <= 1'b0;
            r_state     <= IDLE;
          end
        end

        WAIT_END: begin
          if (!csi.data_valid) begin
            r_in_packet <= 1'b0;
            r_state     <= IDLE;
          end
        end

        default: begin
          r_in_packet <= 1'b0;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign csi.payload_data    = r_payload_data;
  assign csi.payload_valid   = r_payload_valid;
  assign csi.payload_byte_en = r_payload_byte_en;
  assign csi.payload_last    = r_payload_last;
  assign csi.pkt_hdr_valid   = r_pkt_hdr_valid;
  assign csi.pkt_dt          = r_pkt_dt;
  assign csi.pkt_vc          = r_pkt_vc;
  assign csi.pkt_wc          = r_pkt_wc;
  assign csi.frame_start     = r_frame_start;
  assign csi.frame_end       = r_frame_end;
  assign csi.line_start      = r_line_start;
  assign csi.line_end        = r_line_end;
  assign csi.ecc_corrected   = r_ecc_corrected;
  assign csi.ecc_error       = r_ecc_error;
  assign csi.truncated       = r_truncated;
  assign csi.in_packet       = r_in_packet;

endmodule
